// File: rtl/hls_ctrl_sequencer.sv
// Soft-register front end plus an AXI-Lite style master that loads kernel arguments,
// pulses ap_start and polls ap_done, reporting busy/done/error and a busy-cycle count.
module hls_ctrl_sequencer #(
  parameter int unsigned NUM_ARGS = 4,
  parameter logic [31:0] ARG_BASE = 32'h10,
  parameter int unsigned POLL_GAP = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sr_req_valid,
  input  logic        sr_req_isWrite,
  input  logic [31:0] sr_req_addr,
  input  logic [63:0] sr_req_data,
  output logic        sr_resp_valid,
  output logic [63:0] sr_resp_data,
  output logic        ctl_awvalid,
  input  logic        ctl_awready,
  output logic [31:0] ctl_awaddr,
  output logic        ctl_wvalid,
  input  logic        ctl_wready,
  output logic [63:0] ctl_wdata,
  output logic [7:0]  ctl_wstrb,
  input  logic        ctl_bvalid,
  output logic        ctl_bready,
  input  logic [1:0]  ctl_bresp,
  output logic        ctl_arvalid,
  input  logic        ctl_arready,
  output logic [31:0] ctl_araddr,
  input  logic        ctl_rvalid,
  output logic        ctl_rready,
  input  logic [63:0] ctl_rdata,
  input  logic [1:0]  ctl_rresp
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARG_ADDR, S_ARG_RESP, S_START_ADDR,
    S_START_RESP, S_POLL_WAIT, S_POLL_AR, S_POLL_R
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  arg_idx_q, arg_idx_d;
  logic        aw_pend_q, aw_pend_d;
  logic        w_pend_q, w_pend_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [63:0] cycles_q, cycles_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic        resp_valid_q, resp_valid_d;
  logic [63:0] resp_data_q, resp_data_d;
  logic [63:0] args_q [NUM_ARGS];

  logic [4:0]    req_idx;
  logic          wr_req, rd_req, is_idle, start_req;
  logic [63:0]   rd_data, arg_wdata;
  logic [NUM_ARGS-1:0] arg_we;

  assign req_idx   = sr_req_addr[7:3];
  assign wr_req    = sr_req_valid & sr_req_isWrite;
  assign rd_req    = sr_req_valid & ~sr_req_isWrite;
  assign is_idle   = (state_q == S_IDLE);
  assign start_req = wr_req & (req_idx == 5'd0) & sr_req_data[0] & is_idle;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ARGS; gi++) begin : g_arg_we
      assign arg_we[gi] = wr_req & is_idle & (req_idx == 5'(gi + 1));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_ARGS; k++) begin
      if (!rst_n) begin
        args_q[k] <= '0;
      end else if (arg_we[k]) begin
        args_q[k] <= sr_req_data;
      end
    end
  end

  // Read data reflects pre-update state, so a STATUS read racing done sees the old value.
  always_comb begin
    rd_data = '0;
    if (req_idx == 5'd0) begin
      rd_data = {61'b0, error_q, done_q, busy_q};
    end else if (req_idx == 5'(NUM_ARGS + 1)) begin
      rd_data = cycles_q;
    end
    for (int k = 0; k < NUM_ARGS; k++) begin
      if (req_idx == 5'(k + 1)) rd_data = args_q[k];
    end
  end

  always_comb begin
    arg_wdata = '0;
    for (int k = 0; k < NUM_ARGS; k++) begin
      if (arg_idx_q == 5'(k)) arg_wdata = args_q[k];
    end
  end

  always_comb begin
    state_d      = state_q;
    arg_idx_d    = arg_idx_q;
    aw_pend_d    = aw_pend_q;
    w_pend_d     = w_pend_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    cycles_d     = busy_q ? cycles_q + 64'd1 : cycles_q;
    poll_cnt_d   = poll_cnt_q;
    resp_valid_d = rd_req;
    resp_data_d  = rd_req ? rd_data : 64'd0;

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          busy_d    = 1'b1;
          done_d    = 1'b0;
          error_d   = 1'b0;
          cycles_d  = '0;
          arg_idx_d = '0;
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
          state_d   = S_ARG_ADDR;
        end
      end
      S_ARG_ADDR, S_START_ADDR: begin
        // Address and data channels retire independently; move on once both have.
        aw_pend_d = aw_pend_q & ~ctl_awready;
        w_pend_d  = w_pend_q & ~ctl_wready;
        if (!aw_pend_d && !w_pend_d) begin
          state_d = (state_q == S_ARG_ADDR) ? S_ARG_RESP : S_START_RESP;
        end
      end
      S_ARG_RESP: begin
        if (ctl_bvalid) begin
          if (ctl_bresp != 2'b00) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            if (arg_idx_q == 5'(NUM_ARGS - 1)) begin
              state_d = S_START_ADDR;
            end else begin
              arg_idx_d = arg_idx_q + 5'd1;
              state_d   = S_ARG_ADDR;
            end
          end
        end
      end
      S_START_RESP: begin
        if (ctl_bvalid) begin
          if (ctl_bresp != 2'b00) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            poll_cnt_d = '0;
            state_d    = S_POLL_WAIT;
          end
        end
      end
      S_POLL_WAIT: begin
        if (poll_cnt_q == 16'(POLL_GAP - 1)) begin
          state_d = S_POLL_AR;
        end else begin
          poll_cnt_d = poll_cnt_q + 16'd1;
        end
      end
      S_POLL_AR: begin
        if (ctl_arready) state_d = S_POLL_R;
      end
      S_POLL_R: begin
        if (ctl_rvalid) begin
          if (ctl_rresp != 2'b00) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else if (ctl_rdata[1]) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            poll_cnt_d = '0;
            state_d    = S_POLL_WAIT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      arg_idx_q    <= '0;
      aw_pend_q    <= 1'b0;
      w_pend_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cycles_q     <= '0;
      poll_cnt_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      arg_idx_q    <= arg_idx_d;
      aw_pend_q    <= aw_pend_d;
      w_pend_q     <= w_pend_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      cycles_q     <= cycles_d;
      poll_cnt_q   <= poll_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign sr_resp_valid = resp_valid_q;
  assign sr_resp_data  = resp_data_q;
  assign ctl_awvalid   = aw_pend_q;
  assign ctl_wvalid    = w_pend_q;
  assign ctl_awaddr    = (state_q == S_START_ADDR) ? 32'h0 : ARG_BASE + {24'b0, arg_idx_q, 3'b000};
  assign ctl_wdata     = (state_q == S_START_ADDR) ? 64'h1 : arg_wdata;
  assign ctl_wstrb     = 8'hFF;
  assign ctl_bready    = (state_q == S_ARG_RESP) || (state_q == S_START_RESP);
  assign ctl_arvalid   = (state_q == S_POLL_AR);
  assign ctl_araddr    = 32'h0;
  assign ctl_rready    = (state_q == S_POLL_R);

  logic unused_bits;
  assign unused_bits = ^{sr_req_addr[31:8], sr_req_addr[2:0], ctl_rdata[63:2], ctl_rdata[0]};

endmodule

// File: tb/tb_hls_ctrl_sequencer.sv
// Directed bench for hls_ctrl_sequencer: a vector table for idle register access and
// hand-written sequences against a small AXI-Lite slave model with configurable delays/errors.
module tb_hls_ctrl_sequencer;
  localparam int POLL_GAP = 16;

  logic        clk, rst_n;
  logic        sr_req_valid, sr_req_isWrite;
  logic [31:0] sr_req_addr;
  logic [63:0] sr_req_data;
  logic        sr_resp_valid;
  logic [63:0] sr_resp_data;
  logic        ctl_awvalid, ctl_awready, ctl_wvalid, ctl_wready;
  logic [31:0] ctl_awaddr, ctl_araddr;
  logic [63:0] ctl_wdata, ctl_rdata;
  logic [7:0]  ctl_wstrb;
  logic        ctl_bvalid, ctl_bready, ctl_arvalid, ctl_arready, ctl_rvalid, ctl_rready;
  logic [1:0]  ctl_bresp, ctl_rresp;

  hls_ctrl_sequencer #(.NUM_ARGS(4), .ARG_BASE(32'h10), .POLL_GAP(POLL_GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .sr_req_valid(sr_req_valid), .sr_req_isWrite(sr_req_isWrite),
    .sr_req_addr(sr_req_addr), .sr_req_data(sr_req_data),
    .sr_resp_valid(sr_resp_valid), .sr_resp_data(sr_resp_data),
    .ctl_awvalid(ctl_awvalid), .ctl_awready(ctl_awready), .ctl_awaddr(ctl_awaddr),
    .ctl_wvalid(ctl_wvalid), .ctl_wready(ctl_wready), .ctl_wdata(ctl_wdata), .ctl_wstrb(ctl_wstrb),
    .ctl_bvalid(ctl_bvalid), .ctl_bready(ctl_bready), .ctl_bresp(ctl_bresp),
    .ctl_arvalid(ctl_arvalid), .ctl_arready(ctl_arready), .ctl_araddr(ctl_araddr),
    .ctl_rvalid(ctl_rvalid), .ctl_rready(ctl_rready), .ctl_rdata(ctl_rdata), .ctl_rresp(ctl_rresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Slave configuration
  int aw_delay   = 0;
  int done_after = 0;
  int err_at     = -1;
  bit ar_block   = 0;

  // Slave state and logs
  int cyc = 0;
  bit b_pend, r_pend, aw_got, w_got;
  int aw_hi, w_hi, b_num, poll_no, aw_wait;
  int last_ctrl_cyc, last_r_cyc;
  logic [31:0] aw_log[$];
  logic [63:0] w_log[$];
  int aw_len[$];
  int w_len[$];
  int ar_cyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ctl_awvalid) begin
      ctl_awready = (aw_wait >= aw_delay);
      aw_wait++;
    end else begin
      ctl_awready = 1'b0;
      aw_wait = 0;
    end
    ctl_wready  = ctl_wvalid;
    ctl_bvalid  = b_pend;
    ctl_bresp   = (b_num == err_at) ? 2'b10 : 2'b00;
    ctl_arready = ctl_arvalid && !ar_block;
    ctl_rvalid  = r_pend;
    ctl_rdata   = (poll_no >= done_after) ? 64'h2 : 64'h0;
    ctl_rresp   = 2'b00;
  end

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      b_pend = 0; r_pend = 0; aw_got = 0; w_got = 0; aw_hi = 0; w_hi = 0;
    end else begin
      if (sr_req_valid && sr_req_isWrite && sr_req_addr[7:3] == 5'd0 && sr_req_data[0])
        last_ctrl_cyc = cyc;
      if (ctl_awvalid) aw_hi++;
      if (ctl_wvalid) w_hi++;
      if (ctl_awvalid && ctl_awready) begin
        aw_log.push_back(ctl_awaddr); aw_len.push_back(aw_hi); aw_hi = 0; aw_got = 1;
        $display("[%0d] AW addr=%h", cyc, ctl_awaddr);
      end
      if (ctl_wvalid && ctl_wready) begin
        w_log.push_back(ctl_wdata); w_len.push_back(w_hi); w_hi = 0; w_got = 1;
        $display("[%0d] W  data=%h", cyc, ctl_wdata);
      end
      if (ctl_bvalid && ctl_bready) begin
        b_pend = 0; b_num++;
        $display("[%0d] B  resp=%0d", cyc, ctl_bresp);
      end
      if (aw_got && w_got) begin b_pend = 1; aw_got = 0; w_got = 0; end
      if (ctl_arvalid && ctl_arready) begin
        ar_cyc.push_back(cyc); r_pend = 1;
        $display("[%0d] AR addr=%h", cyc, ctl_araddr);
      end
      if (ctl_rvalid && ctl_rready) begin
        r_pend = 0; poll_no++; last_r_cyc = cyc;
        $display("[%0d] R  data=%h", cyc, ctl_rdata);
      end
    end
  end

  task automatic clear_logs();
    aw_log.delete(); w_log.delete(); aw_len.delete(); w_len.delete(); ar_cyc.delete();
    b_num = 0; poll_no = 0;
  endtask

  task automatic sr_write(input logic [31:0] a, input logic [63:0] d);
    @(negedge clk);
    sr_req_valid = 1; sr_req_isWrite = 1; sr_req_addr = a; sr_req_data = d;
    @(negedge clk);
    sr_req_valid = 0;
    $display("[%0d] SR write addr=%h data=%h", cyc, a, d);
  endtask

  task automatic sr_read(input logic [31:0] a, output logic [63:0] d, output logic v);
    @(negedge clk);
    sr_req_valid = 1; sr_req_isWrite = 0; sr_req_addr = a;
    @(negedge clk);
    sr_req_valid = 0;
    v = sr_resp_valid; d = sr_resp_data;
    $display("[%0d] SR read  addr=%h data=%h valid=%0d", cyc, a, d, v);
  endtask

  task automatic wait_idle(output logic [63:0] st);
    logic v;
    bit ok;
    ok = 0;
    st = '0;
    for (int i = 0; i < 600 && !ok; i++) begin
      sr_read(32'h0, st, v);
      if (st[0] == 1'b0) ok = 1;
    end
    check("wait_idle_busy", {63'b0, st[0]}, 64'd0);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [63:0] data;
    logic [63:0] exp;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];
  logic [31:0] exp_aw[5] = '{32'h10, 32'h18, 32'h20, 32'h28, 32'h0};
  logic [63:0] exp_w[5]  = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd1};

  initial begin
    logic [63:0] d, st, c1, c2;
    logic v;
    bit seen;

    vecs[0]  = '{1, 32'h08, 64'd1, 64'd0};
    vecs[1]  = '{1, 32'h10, 64'd2, 64'd0};
    vecs[2]  = '{1, 32'h18, 64'd3, 64'd0};
    vecs[3]  = '{1, 32'h20, 64'd4, 64'd0};
    vecs[4]  = '{0, 32'h08, 64'd0, 64'd1};
    vecs[5]  = '{0, 32'h0C, 64'd0, 64'd1};
    vecs[6]  = '{0, 32'h10, 64'd0, 64'd2};
    vecs[7]  = '{0, 32'h18, 64'd0, 64'd3};
    vecs[8]  = '{0, 32'h20, 64'd0, 64'd4};
    vecs[9]  = '{0, 32'h00, 64'd0, 64'd0};
    vecs[10] = '{1, 32'h00, 64'd2, 64'd0};
    vecs[11] = '{0, 32'h00, 64'd0, 64'd0};
    vecs[12] = '{1, 32'h28, 64'd5, 64'd0};
    vecs[13] = '{0, 32'h28, 64'd0, 64'd0};
    vecs[14] = '{0, 32'h30, 64'd0, 64'd0};
    vecs[15] = '{0, 32'hF8, 64'd0, 64'd0};

    rst_n = 0; sr_req_valid = 0; sr_req_isWrite = 0; sr_req_addr = '0; sr_req_data = '0;
    ctl_awready = 0; ctl_wready = 0; ctl_bvalid = 0; ctl_bresp = 0;
    ctl_arready = 0; ctl_rvalid = 0; ctl_rdata = 0; ctl_rresp = 0;
    clear_logs();

    // Reset state, including a read request presented during reset
    repeat (2) @(negedge clk);
    sr_req_valid = 1;
    @(negedge clk);
    sr_req_valid = 0;
    check("reset_valids", {58'b0, ctl_awvalid, ctl_wvalid, ctl_bready, ctl_arvalid, ctl_rready, sr_resp_valid}, 64'd0);
    check("reset_resp_data", sr_resp_data, 64'd0);
    check("wstrb", {56'b0, ctl_wstrb}, 64'hFF);
    rst_n = 1;

    // Idle register access table
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) begin
        sr_write(vecs[i].addr, vecs[i].data);
      end else begin
        sr_read(vecs[i].addr, d, v);
        check($sformatf("vec%0d_valid", i), {63'b0, v}, 64'd1);
        check($sformatf("vec%0d_data", i), d, vecs[i].exp);
        @(negedge clk);
        check($sformatf("vec%0d_valid_drop", i), {63'b0, sr_resp_valid}, 64'd0);
      end
    end

    // Full sequence: 3 not-done polls then done
    clear_logs(); aw_delay = 0; done_after = 3; err_at = -1;
    sr_write(32'h0, 64'h1);
    sr_read(32'h0, st, v);
    check("seq1_busy", st, 64'h1);
    wait_idle(st);
    check("seq1_status", st, 64'h2);
    check("seq1_aw_count", 64'(aw_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < aw_log.size(); i++) begin
      check($sformatf("seq1_aw%0d", i), {32'b0, aw_log[i]}, {32'b0, exp_aw[i]});
      check($sformatf("seq1_w%0d", i), w_log[i], exp_w[i]);
    end
    check("seq1_ar_count", 64'(ar_cyc.size()), 64'd4);
    for (int i = 1; i < ar_cyc.size(); i++)
      check($sformatf("seq1_ar_gap%0d", i), {63'b0, (ar_cyc[i] - ar_cyc[i-1]) >= POLL_GAP}, 64'd1);
    sr_read(32'h28, c1, v);
    check("seq1_cycles", c1, 64'(last_r_cyc - last_ctrl_cyc));
    repeat (10) @(negedge clk);
    sr_read(32'h28, c2, v);
    check("seq1_cycles_frozen", c2, 64'(last_r_cyc - last_ctrl_cyc));

    // Delayed awready, immediate wready
    clear_logs(); aw_delay = 4; done_after = 0;
    sr_write(32'h0, 64'h1);
    wait_idle(st);
    check("seq2_status", st, 64'h2);
    check("seq2_aw_count", 64'(aw_log.size()), 64'd5);
    if (aw_log.size() >= 2) begin
      check("seq2_awvalid_len", 64'(aw_len[0]), 64'd5);
      check("seq2_wvalid_len", 64'(w_len[0]), 64'd1);
      check("seq2_next_addr", {32'b0, aw_log[1]}, 64'h18);
    end
    check("seq2_b_count", 64'(b_num), 64'd5);

    // Error response on ARG1
    clear_logs(); aw_delay = 0; err_at = 1;
    sr_write(32'h0, 64'h1);
    wait_idle(st);
    check("seq3_status", st, 64'h4);
    check("seq3_aw_count", 64'(aw_log.size()), 64'd2);
    check("seq3_ar_count", 64'(ar_cyc.size()), 64'd0);
    err_at = -1;

    // Writes while busy are ignored; unmapped read returns 0 one cycle later
    clear_logs(); done_after = 2;
    sr_write(32'h0, 64'h1);
    sr_write(32'h0, 64'h1);
    sr_write(32'h08, 64'd99);
    sr_read(32'hF8, d, v);
    check("seq4_unmapped_valid", {63'b0, v}, 64'd1);
    check("seq4_unmapped_data", d, 64'd0);
    wait_idle(st);
    check("seq4_status", st, 64'h2);
    sr_read(32'h08, d, v);
    check("seq4_arg0", d, 64'd1);
    check("seq4_aw_count", 64'(aw_log.size()), 64'd5);
    if (w_log.size() > 0) check("seq4_w0", w_log[0], 64'd1);

    // Reset while in POLL_AR
    clear_logs(); ar_block = 1; done_after = 0;
    sr_write(32'h0, 64'h1);
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (ctl_arvalid) seen = 1;
    end
    check("seq5_reached_poll_ar", {63'b0, seen}, 64'd1);
    rst_n = 0;
    @(negedge clk);
    check("seq5_arvalid_after_reset", {63'b0, ctl_arvalid}, 64'd0);
    rst_n = 1; ar_block = 0;
    sr_read(32'h0, d, v);
    check("seq5_status", d, 64'd0);
    sr_read(32'h28, d, v);
    check("seq5_cycles", d, 64'd0);
    sr_read(32'h08, d, v);
    check("seq5_arg0", d, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
